// File: rtl/id_ex_if.sv
// ID/EX pipeline register bus: ID-stage inputs, EX-stage outputs, hazard stall and bubble count.
// The master side is the surrounding pipeline; the slave side is the ID/EX register itself.
interface id_ex_if #(
    parameter int CNT_W = 16
);
    logic             mem_stall_i;
    logic             flush_i;
    logic             id_RegWrite_i;
    logic             id_MemtoReg_i;
    logic             id_MemRead_i;
    logic             id_MemWrite_i;
    logic             id_ALUSrc_i;
    logic             id_RegDst_i;
    logic [1:0]       id_ALUOp_i;
    logic [31:0]      id_RSdata_i;
    logic [31:0]      id_RTdata_i;
    logic [31:0]      id_imm_i;
    logic [4:0]       id_RS_i;
    logic [4:0]       id_RT_i;
    logic [4:0]       id_RD_i;

    logic             ie_RegWrite_o;
    logic             ie_MemtoReg_o;
    logic             ie_MemRead_o;
    logic             ie_MemWrite_o;
    logic             ie_ALUSrc_o;
    logic             ie_RegDst_o;
    logic [1:0]       ie_ALUOp_o;
    logic [31:0]      ie_RSdata_o;
    logic [31:0]      ie_RTdata_o;
    logic [31:0]      ie_imm_o;
    logic [4:0]       ie_RS_o;
    logic [4:0]       ie_RT_o;
    logic [4:0]       ie_RD_o;
    logic             ie_valid_o;
    logic             hazard_stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output mem_stall_i, flush_i,
        output id_RegWrite_i, id_MemtoReg_i, id_MemRead_i, id_MemWrite_i, id_ALUSrc_i, id_RegDst_i,
        output id_ALUOp_i, id_RSdata_i, id_RTdata_i, id_imm_i, id_RS_i, id_RT_i, id_RD_i,
        input  ie_RegWrite_o, ie_MemtoReg_o, ie_MemRead_o, ie_MemWrite_o, ie_ALUSrc_o, ie_RegDst_o,
        input  ie_ALUOp_o, ie_RSdata_o, ie_RTdata_o, ie_imm_o, ie_RS_o, ie_RT_o, ie_RD_o,
        input  ie_valid_o, hazard_stall_o, bubble_cnt_o
    );

    modport slave (
        input  mem_stall_i, flush_i,
        input  id_RegWrite_i, id_MemtoReg_i, id_MemRead_i, id_MemWrite_i, id_ALUSrc_i, id_RegDst_i,
        input  id_ALUOp_i, id_RSdata_i, id_RTdata_i, id_imm_i, id_RS_i, id_RT_i, id_RD_i,
        output ie_RegWrite_o, ie_MemtoReg_o, ie_MemRead_o, ie_MemWrite_o, ie_ALUSrc_o, ie_RegDst_o,
        output ie_ALUOp_o, ie_RSdata_o, ie_RTdata_o, ie_imm_o, ie_RS_o, ie_RT_o, ie_RD_o,
        output ie_valid_o, hazard_stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of load-use bubbles.
module id_ex_register #(
    parameter int CNT_W = 16
) (
    input logic    clk_i,
    input logic    rst_i,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic        reg_write;
        logic        memto_reg;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            w_id_slot;
    slot_t            r_slot;
    logic             r_valid;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_hazard;
    logic             w_bubble;
    logic             w_count;

    assign w_id_slot = '{
        reg_write: bus.id_RegWrite_i,
        memto_reg: bus.id_MemtoReg_i,
        mem_read:  bus.id_MemRead_i,
        mem_write: bus.id_MemWrite_i,
        alu_src:   bus.id_ALUSrc_i,
        reg_dst:   bus.id_RegDst_i,
        alu_op:    bus.id_ALUOp_i,
        rs_data:   bus.id_RSdata_i,
        rt_data:   bus.id_RTdata_i,
        imm:       bus.id_imm_i,
        rs:        bus.id_RS_i,
        rt:        bus.id_RT_i,
        rd:        bus.id_RD_i
    };

    // A load in EX whose destination is read by the instruction in ID; $0 never hazards.
    assign w_hazard = r_valid & r_slot.mem_read & (r_slot.rt != 5'd0) &
                      ((r_slot.rt == bus.id_RS_i) | (r_slot.rt == bus.id_RT_i));
    assign w_bubble = bus.flush_i | w_hazard;
    assign w_count  = ~bus.flush_i & w_hazard & (r_bubble_cnt != CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_slot       <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (!bus.mem_stall_i) begin
            if (w_bubble) begin
                r_slot  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_slot  <= w_id_slot;
                r_valid <= 1'b1;
            end
            if (w_count) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ie_RegWrite_o  = r_slot.reg_write;
    assign bus.ie_MemtoReg_o  = r_slot.memto_reg;
    assign bus.ie_MemRead_o   = r_slot.mem_read;
    assign bus.ie_MemWrite_o  = r_slot.mem_write;
    assign bus.ie_ALUSrc_o    = r_slot.alu_src;
    assign bus.ie_RegDst_o    = r_slot.reg_dst;
    assign bus.ie_ALUOp_o     = r_slot.alu_op;
    assign bus.ie_RSdata_o    = r_slot.rs_data;
    assign bus.ie_RTdata_o    = r_slot.rt_data;
    assign bus.ie_imm_o       = r_slot.imm;
    assign bus.ie_RS_o        = r_slot.rs;
    assign bus.ie_RT_o        = r_slot.rt;
    assign bus.ie_RD_o        = r_slot.rd;
    assign bus.ie_valid_o     = r_valid;
    assign bus.hazard_stall_o = w_hazard;
    assign bus.bubble_cnt_o   = r_bubble_cnt;
endmodule
